disp_data_driver_mc: RTL and testbench
======================================

// Module: disp_data_driver_mc
// PURPOSE
//  Multi-channel, command-queued dispatch data driver.
//  Accepts (length, channel) transfer commands into a small command FIFO.
//  For each command, streams exactly that many beats from the selected source channel to one output stream, with XDLAST on the final beat.
//  Sits between per-channel data producers and the single downstream dispatch port.
//  Queued commands run back-to-back with no idle bubble.
// PARAMETERS
//  DataWidth    32  data beat width (bits)
//  LengthWidth  16  transfer length field width, in beats
//  NumChannels  4   number of source data channels (>=1)
//  CmdDepth     4   command FIFO entries (power of 2, >=2)
//  ChanWidth    -   localparam: max(1, $clog2(NumChannels))
// PORTS
//  CLK       in   1                        clock
//  RESET     in   1                        synchronous, active-high reset
//  SRCLEN    in   LengthWidth              command transfer length, in beats
//  SRCCHAN   in   ChanWidth                command source channel
//  SRCVALID  in   1                        command valid
//  SRCREADY  out  1                        command ready (FIFO not full)
//  DATA      in   NumChannels*DataWidth    channel data; channel i at [i*DataWidth +: DataWidth]
//  DVALID    in   NumChannels              per-channel data valid
//  DREADY    out  NumChannels              per-channel data ready
//  XDATA     out  DataWidth                output data
//  XDVALID   out  1                        output valid
//  XDREADY   in   1                        output ready
//  XDLAST    out  1                        last beat of the current transfer
//  XCHAN     out  ChanWidth                channel of the current transfer
//  BUSY      out  1                        transfer active or commands queued
// BEHAVIOUR
//  Reset and handshakes
//  - Reset: FIFO emptied, state IDLE, count/len/chan = 0.
//  - Every output is 0 during and after reset, except SRCREADY: 0 while RESET is high, 1 after.
//  - Command handshake: accepted on SRCVALID && SRCREADY. SRCREADY = !full && !RESET.
//  - SRCLEN == 0: command is accepted and dropped (never enqueued). SRCCHAN >= NumChannels: also accepted and dropped.
//  - A command pushed into an empty FIFO is visible to the FSM one cycle later.
//  - Push and pop in the same cycle are legal; occupancy is unchanged.
//  - Beat: in STREAM, a beat transfers when DVALID[rChan] && XDREADY.
//  Output signals
//  - XDVALID = STREAM && DVALID[rChan].
//  - DREADY[i] = STREAM && (i == rChan) && XDREADY. Non-selected channels always see 0.
//  - XDATA = DATA slice of rChan. It is combinational, and is don't-care when XDVALID = 0.
//  - XDLAST = STREAM && (rCount == rLen), where rLen = SRCLEN - 1, latched at pop.
//  - XCHAN = rChan. BUSY = STREAM || !empty.
//  State machine
//  - IDLE: if FIFO non-empty, pop the head, latch rLen/rChan, clear rCount, go to STREAM.
//  - STREAM: on each beat, rCount += 1.
//  - On the last beat with FIFO non-empty: pop the next command in the same cycle, reload rLen/rChan/rCount, stay in STREAM (zero bubble).
//  - On the last beat with FIFO empty: go to IDLE.
//  Arithmetic and boundaries
//  - rCount and rLen are LengthWidth wide; maximum transfer is 2^LengthWidth - 1 beats. rCount never wraps.
//  - Backpressure: XDREADY = 0 stalls the transfer. rCount holds and XDATA/XDVALID follow the source.
//  - Reset mid-transfer: the transfer is aborted with no XDLAST, and queued commands are discarded.
// CONFIGURATION
//  DISP_BEAT_CNT_EN defined:
//  - Adds output BEATCNT[31:0]: a free-running count of transferred beats.
//  - Cleared by RESET; increments on every beat; wraps at 2^32.
//  - Adds output CMDDROP (1 bit): a sticky flag, set when a zero-length or bad-channel command is dropped, cleared by RESET.
//  DISP_BEAT_CNT_EN undefined: these ports and their logic are absent.
// STRUCTURE
//  - Package disp_pkg: state encoding (DISP_IDLE = 1'b0, DISP_STREAM = 1'b1), the clog2 helper function, and the command-entry packing width (LengthWidth + ChanWidth).
//  - Sub-module disp_cmd_fifo: synchronous FIFO, CmdDepth x (LengthWidth + ChanWidth).
//    - Ports: push, pop, din, dout, full, empty. dout is first-word-fall-through.
//  - Top level: FSM, counters, channel mux, DREADY decode.
// TESTING
//  1. Cmd (len 4, ch0), DVALID[0] = 1, XDREADY = 1.
//     -> 4 XDVALID beats carrying ch0 data; XDLAST on the 4th only; DREADY = 4'b0001 during the transfer; then IDLE, BUSY = 0.
//  2. Cmds (3, ch1) and (2, ch2) queued back-to-back.
//     -> 5 consecutive beats, no bubble; XDLAST on beats 3 and 5; XCHAN changes 1 -> 2 in the cycle after beat 3.
//  3. Cmds (0, ch1) then (1, ch3).
//     -> The zero-length cmd produces no beats. A single beat comes from ch3 with XDLAST = 1.
//     -> With the macro: CMDDROP = 1.
//  4. Six cmds pushed while XDREADY = 0 (CmdDepth = 4).
//     -> SRCREADY goes low after 4 entries in the FIFO plus 1 active.
//     -> Releasing XDREADY drains all six in order.
//  5. Cmd (8, ch0) with XDREADY toggling 1010... and DVALID[0] toggling.
//     -> Exactly 8 handshakes; rCount holds on stalls; XDLAST only with the 8th.
//  6. RESET asserted after 3 of 10 beats, with 2 cmds queued.
//     -> Next cycle: XDVALID = 0, BUSY = 0, DREADY = 0, FIFO empty; no further beats.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : disp_pkg                                                   |
// | Shared state encoding and sizing helpers for the dispatch driver.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package disp_pkg;

  typedef enum logic [0:0] {
    DISP_IDLE   = 1'b0,
    DISP_STREAM = 1'b1
  } disp_state_e;

  // Ceiling log2, floored at 1 so a single channel still gets a 1-bit select.
  function automatic int disp_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int disp_cmd_width(input int len_w, input int chan_w);
    return len_w + chan_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : disp_cmd_fifo                                              |
// | Synchronous first-word-fall-through command FIFO.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module disp_cmd_fifo
  import disp_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 18
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_addr_w = disp_clog2(Depth);
  localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

  logic [Width-1:0]  r_mem [Depth];
  logic [c_addr_w:0] r_wptr;
  logic [c_addr_w:0] r_rptr;
  logic              w_wr;
  logic              w_rd;

  assign w_wr = push && !full;
  assign w_rd = pop && !empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + c_ptr_one;
      if (w_rd) r_rptr <= r_rptr + c_ptr_one;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr[c_addr_w-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                 (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
  assign dout  = r_mem[r_rptr[c_addr_w-1:0]];

endmodule
`default_nettype wire

// File: rtl/disp_data_driver_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : disp_data_driver_mc                                        |
// | Command-queued multi-channel dispatch driver. DISP_BEAT_CNT_EN adds  |
// | BEATCNT and CMDDROP outputs.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module disp_data_driver_mc
  import disp_pkg::*;
#(
  parameter  int DataWidth   = 32,
  parameter  int LengthWidth = 16,
  parameter  int NumChannels = 4,
  parameter  int CmdDepth    = 4,
  localparam int ChanWidth   = disp_clog2(NumChannels)
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [LengthWidth-1:0]           SRCLEN,
  input  logic [ChanWidth-1:0]             SRCCHAN,
  input  logic                             SRCVALID,
  output logic                             SRCREADY,
  input  logic [NumChannels*DataWidth-1:0] DATA,
  input  logic [NumChannels-1:0]           DVALID,
  output logic [NumChannels-1:0]           DREADY,
  output logic [DataWidth-1:0]             XDATA,
  output logic                             XDVALID,
  input  logic                             XDREADY,
  output logic                             XDLAST,
  output logic [ChanWidth-1:0]             XCHAN,
  output logic                             BUSY
`ifdef DISP_BEAT_CNT_EN
  ,
  output logic [31:0]                      BEATCNT,
  output logic                             CMDDROP
`endif
);

  localparam int c_cmd_w = disp_cmd_width(LengthWidth, ChanWidth);
  localparam logic [LengthWidth-1:0] c_len_one = LengthWidth'(1);

  disp_state_e            r_state;
  disp_state_e            w_state_nxt;
  logic [LengthWidth-1:0] r_count;
  logic [LengthWidth-1:0] r_len;
  logic [ChanWidth-1:0]   r_chan;

  logic [c_cmd_w-1:0]     w_fifo_dout;
  logic [LengthWidth-1:0] w_head_len;
  logic [ChanWidth-1:0]   w_head_chan;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_cmd_ok;
  logic                   w_cmd_acc;
  logic                   w_stream;
  logic                   w_beat;
  logic                   w_last;
  logic                   w_xdvalid;
  logic [DataWidth-1:0]   w_chan_data [NumChannels];

  // Zero-length and out-of-range commands are handshaken but never queued.
  assign w_cmd_ok  = (SRCLEN != '0) && (int'(SRCCHAN) < NumChannels);
  assign w_cmd_acc = SRCVALID && SRCREADY;
  assign w_push    = w_cmd_acc && w_cmd_ok;

  disp_cmd_fifo #(
    .Depth (CmdDepth),
    .Width (c_cmd_w)
  ) u_cmd_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({SRCLEN, SRCCHAN}),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign {w_head_len, w_head_chan} = w_fifo_dout;

  assign w_stream = (r_state == DISP_STREAM);
  assign w_beat   = w_stream && DVALID[r_chan] && XDREADY;
  assign w_last   = (r_count == r_len);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= DISP_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Popping on the final beat reloads the next command with no idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      DISP_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = DISP_STREAM;
        end
      end
      DISP_STREAM: begin
        if (w_beat && w_last) begin
          if (!w_empty) w_pop       = 1'b1;
          else          w_state_nxt = DISP_IDLE;
        end
      end
      default: w_state_nxt = DISP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
      r_len   <= '0;
      r_chan  <= '0;
    end else if (w_pop) begin
      r_count <= '0;
      r_len   <= w_head_len - c_len_one;
      r_chan  <= w_head_chan;
    end else if (w_beat) begin
      r_count <= r_count + c_len_one;
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    assign w_chan_data[g] = DATA[g*DataWidth +: DataWidth];
    assign DREADY[g]      = w_stream && (r_chan == ChanWidth'(g)) && XDREADY && !RESET;
  end

  assign w_xdvalid = w_stream && DVALID[r_chan] && !RESET;
  assign XDVALID   = w_xdvalid;
  assign XDATA     = w_xdvalid ? w_chan_data[r_chan] : '0;
  assign XDLAST    = w_stream && w_last && !RESET;
  assign XCHAN     = RESET ? '0 : r_chan;
  assign BUSY      = (w_stream || !w_empty) && !RESET;
  assign SRCREADY  = !w_full && !RESET;

`ifdef DISP_BEAT_CNT_EN
  logic [31:0] r_beatcnt;
  logic        r_cmddrop;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_beatcnt <= '0;
      r_cmddrop <= 1'b0;
    end else begin
      if (w_beat)                r_beatcnt <= r_beatcnt + 32'd1;
      if (w_cmd_acc && !w_cmd_ok) r_cmddrop <= 1'b1;
    end
  end

  assign BEATCNT = r_beatcnt;
  assign CMDDROP = r_cmddrop;
`else
  // Beat counter and drop flag are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_data_driver_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_disp_data_driver_mc                                     |
// | Directed self-checking bench for disp_data_driver_mc.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_disp_data_driver_mc;

  logic         CLK;
  logic         RESET;
  logic [15:0]  SRCLEN;
  logic [1:0]   SRCCHAN;
  logic         SRCVALID;
  logic         SRCREADY;
  logic [127:0] DATA;
  logic [3:0]   DVALID;
  logic [3:0]   DREADY;
  logic [31:0]  XDATA;
  logic         XDVALID;
  logic         XDREADY;
  logic         XDLAST;
  logic [1:0]   XCHAN;
  logic         BUSY;
`ifdef DISP_BEAT_CNT_EN
  logic [31:0]  BEATCNT;
  logic         CMDDROP;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  disp_data_driver_mc dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .SRCLEN   (SRCLEN),
    .SRCCHAN  (SRCCHAN),
    .SRCVALID (SRCVALID),
    .SRCREADY (SRCREADY),
    .DATA     (DATA),
    .DVALID   (DVALID),
    .DREADY   (DREADY),
    .XDATA    (XDATA),
    .XDVALID  (XDVALID),
    .XDREADY  (XDREADY),
    .XDLAST   (XDLAST),
    .XCHAN    (XCHAN),
    .BUSY     (BUSY)
`ifdef DISP_BEAT_CNT_EN
    ,
    .BEATCNT  (BEATCNT),
    .CMDDROP  (CMDDROP)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] chdat(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic drive_cmd(input int len, input int ch);
    SRCVALID = 1'b1;
    SRCLEN   = 16'(len);
    SRCCHAN  = 2'(ch);
    cyc();
  endtask

  logic [1:0]  q_ch   [$];
  logic        q_last [$];
  logic [31:0] q_dat  [$];
  int          exp_ch   [8] = '{0, 1, 1, 2, 3, 3, 1, 0};
  int          exp_last [8] = '{1, 0, 1, 1, 0, 1, 1, 1};

  initial begin
    int  hs;
    bit  c6_acc;
    RESET    = 1'b1;
    SRCLEN   = '0;
    SRCCHAN  = '0;
    SRCVALID = 1'b0;
    DVALID   = '0;
    XDREADY  = 1'b0;
    DATA     = {chdat(3), chdat(2), chdat(1), chdat(0)};

    // Reset behaviour
    cyc(); cyc();
    mid();
    chk("rst_srcready", 32'(SRCREADY), 0);
    chk("rst_xdvalid", 32'(XDVALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_dready", 32'(DREADY), 0);
    chk("rst_xdlast", 32'(XDLAST), 0);
    chk("rst_xchan", 32'(XCHAN), 0);
    cyc();
    RESET = 1'b0;
    mid();
    chk("post_rst_srcready", 32'(SRCREADY), 1);
    chk("post_rst_busy", 32'(BUSY), 0);
    chk("post_rst_xdvalid", 32'(XDVALID), 0);
    cyc();

    // 1: single 4-beat transfer on channel 0
    DVALID  = 4'b0001;
    XDREADY = 1'b1;
    drive_cmd(4, 0);
    SRCVALID = 1'b0;
    mid();
    chk("t1_busy_queued", 32'(BUSY), 1);
    chk("t1_no_early_valid", 32'(XDVALID), 0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      mid();
      chk($sformatf("t1_xdvalid_b%0d", b), 32'(XDVALID), 1);
      chk($sformatf("t1_xdata_b%0d", b), XDATA, chdat(0));
      chk($sformatf("t1_dready_b%0d", b), 32'(DREADY), 32'h1);
      chk($sformatf("t1_xdlast_b%0d", b), 32'(XDLAST), (b == 3) ? 1 : 0);
      cyc();
    end
    mid();
    chk("t1_idle_xdvalid", 32'(XDVALID), 0);
    chk("t1_idle_busy", 32'(BUSY), 0);
    chk("t1_idle_dready", 32'(DREADY), 0);
`ifdef DISP_BEAT_CNT_EN
    chk("t1_beatcnt", BEATCNT, 4);
`endif

    // 2: back-to-back commands, no bubble
    DVALID = 4'b1111;
    drive_cmd(3, 1);
    drive_cmd(2, 2);
    SRCVALID = 1'b0;
    for (int b = 0; b < 5; b++) begin
      mid();
      chk($sformatf("t2_xdvalid_b%0d", b), 32'(XDVALID), 1);
      chk($sformatf("t2_xchan_b%0d", b), 32'(XCHAN), (b < 3) ? 1 : 2);
      chk($sformatf("t2_xdata_b%0d", b), XDATA, chdat((b < 3) ? 1 : 2));
      chk($sformatf("t2_xdlast_b%0d", b), 32'(XDLAST), (b == 2 || b == 4) ? 1 : 0);
      chk($sformatf("t2_dready_b%0d", b), 32'(DREADY), (b < 3) ? 32'h2 : 32'h4);
      cyc();
    end
    mid();
    chk("t2_idle_xdvalid", 32'(XDVALID), 0);
    chk("t2_idle_busy", 32'(BUSY), 0);

    // 3: zero-length command dropped, then single beat from channel 3
    drive_cmd(0, 1);
    mid();
    chk("t3_drop_busy", 32'(BUSY), 0);
    chk("t3_drop_xdvalid", 32'(XDVALID), 0);
    drive_cmd(1, 3);
    SRCVALID = 1'b0;
    mid();
    chk("t3_queued_xdvalid", 32'(XDVALID), 0);
    chk("t3_queued_busy", 32'(BUSY), 1);
    cyc();
    mid();
    chk("t3_xdvalid", 32'(XDVALID), 1);
    chk("t3_xchan", 32'(XCHAN), 3);
    chk("t3_xdata", XDATA, chdat(3));
    chk("t3_xdlast", 32'(XDLAST), 1);
    chk("t3_dready", 32'(DREADY), 32'h8);
    cyc();
    mid();
    chk("t3_idle_xdvalid", 32'(XDVALID), 0);
    chk("t3_idle_busy", 32'(BUSY), 0);
`ifdef DISP_BEAT_CNT_EN
    chk("t3_cmddrop", 32'(CMDDROP), 1);
`endif

    // 4: fill the queue under backpressure, then drain in order
    XDREADY = 1'b0;
    drive_cmd(1, 0);
    drive_cmd(2, 1);
    drive_cmd(1, 2);
    drive_cmd(2, 3);
    drive_cmd(1, 1);
    SRCVALID = 1'b1;
    SRCLEN   = 16'd1;
    SRCCHAN  = 2'd0;
    mid();
    chk("t4_full_srcready", 32'(SRCREADY), 0);
    chk("t4_stall_xdvalid", 32'(XDVALID), 1);
    chk("t4_stall_dready", 32'(DREADY), 0);
    chk("t4_stall_xchan", 32'(XCHAN), 0);
    chk("t4_stall_busy", 32'(BUSY), 1);
    cyc();
    mid();
    chk("t4_full_srcready_hold", 32'(SRCREADY), 0);
    cyc();
    XDREADY = 1'b1;
    for (int k = 0; k < 30; k++) begin
      mid();
      if (XDVALID && XDREADY) begin
        q_ch.push_back(XCHAN);
        q_last.push_back(XDLAST);
        q_dat.push_back(XDATA);
      end
      c6_acc = SRCVALID && SRCREADY;
      cyc();
      if (c6_acc) SRCVALID = 1'b0;
    end
    chk("t4_nbeats", 32'(q_ch.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q_ch.size()) begin
        chk($sformatf("t4_xchan_b%0d", i), 32'(q_ch[i]), 32'(exp_ch[i]));
        chk($sformatf("t4_xdlast_b%0d", i), 32'(q_last[i]), 32'(exp_last[i]));
        chk($sformatf("t4_xdata_b%0d", i), q_dat[i], chdat(exp_ch[i]));
      end
    end
    mid();
    chk("t4_idle_busy", 32'(BUSY), 0);
    chk("t4_c6_taken", 32'(SRCVALID), 0);

    // 5: 8-beat transfer with toggling ready and valid
    XDREADY = 1'b0;
    DVALID  = 4'b0000;
    drive_cmd(8, 0);
    SRCVALID = 1'b0;
    hs = 0;
    for (int k = 0; k < 80 && hs < 8; k++) begin
      XDREADY   = (k % 2 == 0);
      DVALID[0] = (k % 3 != 2);
      mid();
      if (hs > 0) begin
        chk($sformatf("t5_xdvalid_k%0d", k), 32'(XDVALID), 32'(DVALID[0]));
        chk($sformatf("t5_dready_k%0d", k), 32'(DREADY), 32'(XDREADY));
      end
      if (XDVALID && XDREADY) begin
        chk($sformatf("t5_xdlast_hs%0d", hs), 32'(XDLAST), (hs == 7) ? 1 : 0);
        chk($sformatf("t5_xdata_hs%0d", hs), XDATA, chdat(0));
        hs++;
      end
      cyc();
    end
    chk("t5_handshakes", 32'(hs), 8);
    XDREADY = 1'b1;
    DVALID  = 4'b1111;
    mid();
    chk("t5_idle_xdvalid", 32'(XDVALID), 0);
    chk("t5_idle_busy", 32'(BUSY), 0);
    cyc();

    // 6: reset in the middle of a 10-beat transfer with commands queued
    drive_cmd(10, 2);
    drive_cmd(3, 1);
    drive_cmd(4, 3);
    SRCVALID = 1'b0;
    cyc();
    mid();
    chk("t6_pre_xdvalid", 32'(XDVALID), 1);
    chk("t6_pre_xchan", 32'(XCHAN), 2);
    chk("t6_pre_xdlast", 32'(XDLAST), 0);
    cyc();
    RESET = 1'b1;
    mid();
    chk("t6_rst_xdvalid", 32'(XDVALID), 0);
    chk("t6_rst_busy", 32'(BUSY), 0);
    chk("t6_rst_dready", 32'(DREADY), 0);
    chk("t6_rst_srcready", 32'(SRCREADY), 0);
    cyc();
    RESET = 1'b0;
    mid();
    chk("t6_post_xdvalid", 32'(XDVALID), 0);
    chk("t6_post_busy", 32'(BUSY), 0);
    chk("t6_post_dready", 32'(DREADY), 0);
    chk("t6_post_xdlast", 32'(XDLAST), 0);
    chk("t6_post_xchan", 32'(XCHAN), 0);
    chk("t6_post_srcready", 32'(SRCREADY), 1);
    cyc(); cyc(); cyc();
    mid();
    chk("t6_late_xdvalid", 32'(XDVALID), 0);
    chk("t6_late_busy", 32'(BUSY), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
